control_unit: RTL and testbench

Hardwired control-unit FSM that sequences the CPU datapath through fetch (T0–T2) and per-opcode execute steps, replacing the hand-driven control sequences used in the phase-2 benches. It reads the instruction register and the branch condition flag from the datapath. It drives every datapath enable, bus-select, memory and ALU-select signal, one state per clock.

---
 rtl/cpu_ctrl_pkg.sv | 81 ++++++++
 rtl/ctrl_opdecode.sv | 38 +++
 rtl/control_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM states,
// instruction classes and the control-word layout driven onto the datapath.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ADDR_OP_DEFAULT = 5'b00011;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2,
        ST_E3, ST_E4, ST_E5, ST_E6, ST_E7,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_HALT, CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_ADDI,
        CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_MULDIV
    } instr_class_t;

    typedef struct packed {
        logic       pc_in;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       con_in;
        logic       outport_in;
        logic       pc_out;
        logic       mdr_out;
        logic       y_out;
        logic       zhi_out;
        logic       zlo_out;
        logic       hi_out;
        logic       lo_out;
        logic       inport_out;
        logic       c_out;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       read;
        logic       write;
        logic       inc_pc;
        logic [4:0] alu_op;
    } ctrl_word_t;

    // Number of execute states (E3 onward) each instruction class occupies.
    function automatic logic [2:0] exec_length(input instr_class_t cls);
        case (cls)
            CLS_LD, CLS_ST:              return 3'd5;
            CLS_BR, CLS_MULDIV:          return 3'd4;
            CLS_LDI, CLS_ALU, CLS_ADDI:  return 3'd3;
            CLS_JR, CLS_IN, CLS_OUT,
            CLS_MFHI, CLS_MFLO:          return 3'd1;
            default:                     return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode classifier: IR[31:27] -> instruction class and length.
// mul/div are recognised only when CTRL_MULDIV_EN is defined.
module ctrl_opdecode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t instr_class,
    output logic [2:0]   exec_len
);

    always_comb begin
        instr_class = CLS_NOP;
        case (opcode)
            OP_LD:                         instr_class = CLS_LD;
            OP_LDI:                        instr_class = CLS_LDI;
            OP_ST:                         instr_class = CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR: instr_class = CLS_ALU;
            OP_ADDI:                       instr_class = CLS_ADDI;
            OP_BR:                         instr_class = CLS_BR;
            OP_JR:                         instr_class = CLS_JR;
            OP_IN:                         instr_class = CLS_IN;
            OP_OUT:                        instr_class = CLS_OUT;
            OP_MFHI:                       instr_class = CLS_MFHI;
            OP_MFLO:                       instr_class = CLS_MFLO;
            OP_HALT:                       instr_class = CLS_HALT;
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV:                instr_class = CLS_MULDIV;
`else
            OP_MUL, OP_DIV:                instr_class = CLS_NOP;
`endif
            OP_NOP:                        instr_class = CLS_NOP;
            default:                       instr_class = CLS_NOP;
        endcase
    end

    assign exec_len = exec_length(instr_class);

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch T0-T2 then per-opcode execute states E3-E7.
// Optional mul/div sequencing is enabled by defining CTRL_MULDIV_EN.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter logic [4:0] ADDR_OP = ADDR_OP_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Stop,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONin,
    output logic        OUTPORTin,
    output logic        PCout,
    output logic        MDRout,
    output logic        Yout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        HIout,
    output logic        LOout,
    output logic        INPORTout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Read,
    output logic        write,
    output logic        IncPC,
    output logic [4:0]  ALUop,
    output logic        Run
);

    state_t       state_q, state_d;
    instr_class_t instr_class;
    logic [2:0]   exec_len;
    logic [4:0]   opcode;
    logic [2:0]   ex_step;
    logic         in_exec;
    ctrl_word_t   cw;
    logic         ir_unused;

    assign opcode    = IR[31:27];
    assign ir_unused = ^IR[26:0];

    ctrl_opdecode u_opdecode (
        .opcode      (opcode),
        .instr_class (instr_class),
        .exec_len    (exec_len)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = Stop ? ST_HALT : ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2: begin
                if (instr_class == CLS_HALT) begin
                    state_d = ST_HALT;
                end else if (exec_len == 3'd0) begin
                    state_d = ST_T0;
                end else begin
                    state_d = ST_E3;
                end
            end
            ST_E3:   state_d = (exec_len > 3'd1) ? ST_E4 : ST_T0;
            ST_E4:   state_d = (exec_len > 3'd2) ? ST_E5 : ST_T0;
            ST_E5:   state_d = (exec_len > 3'd3) ? ST_E6 : ST_T0;
            ST_E6:   state_d = (exec_len > 3'd4) ? ST_E7 : ST_T0;
            ST_E7:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // A pending Stop in T0 suppresses the fetch so the PC is left untouched.
    always_comb begin
        cw      = '0;
        in_exec = 1'b0;
        ex_step = 3'd0;
        case (state_q)
            ST_T0: begin
                if (!Stop) begin
                    cw.pc_out = 1'b1;
                    cw.mar_in = 1'b1;
                    cw.inc_pc = 1'b1;
                    cw.z_in   = 1'b1;
                end
            end
            ST_T1: begin
                cw.zlo_out = 1'b1;
                cw.pc_in   = 1'b1;
                cw.read    = 1'b1;
                cw.mdr_in  = 1'b1;
            end
            ST_T2: begin
                cw.mdr_out = 1'b1;
                cw.ir_in   = 1'b1;
            end
            ST_E3: begin in_exec = 1'b1; ex_step = 3'd0; end
            ST_E4: begin in_exec = 1'b1; ex_step = 3'd1; end
            ST_E5: begin in_exec = 1'b1; ex_step = 3'd2; end
            ST_E6: begin in_exec = 1'b1; ex_step = 3'd3; end
            ST_E7: begin in_exec = 1'b1; ex_step = 3'd4; end
            default: ;
        endcase

        if (in_exec) begin
            case (instr_class)
                CLS_LD, CLS_ST: begin
                    case (ex_step)
                        3'd0: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1; end
                        3'd1: begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = ADDR_OP; end
                        3'd2: begin cw.zlo_out = 1'b1; cw.mar_in = 1'b1; end
                        3'd3: begin
                            if (instr_class == CLS_LD) begin
                                cw.read   = 1'b1;
                                cw.mdr_in = 1'b1;
                            end else begin
                                cw.gra    = 1'b1;
                                cw.r_out  = 1'b1;
                                cw.mdr_in = 1'b1;
                            end
                        end
                        3'd4: begin
                            if (instr_class == CLS_LD) begin
                                cw.mdr_out = 1'b1;
                                cw.gra     = 1'b1;
                                cw.r_in    = 1'b1;
                            end else begin
                                cw.write = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                CLS_LDI, CLS_ADDI: begin
                    case (ex_step)
                        3'd0: begin
                            cw.grb  = 1'b1;
                            cw.y_in = 1'b1;
                            if (instr_class == CLS_LDI) cw.ba_out = 1'b1;
                            else                        cw.r_out  = 1'b1;
                        end
                        3'd1: begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = ADDR_OP; end
                        3'd2: begin cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
                        default: ;
                    endcase
                end
                CLS_ALU: begin
                    case (ex_step)
                        3'd0: begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
                        3'd1: begin cw.grc = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = opcode; end
                        3'd2: begin cw.zlo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
                        default: ;
                    endcase
                end
                CLS_MULDIV: begin
                    case (ex_step)
                        3'd0: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
                        3'd1: begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = opcode; end
                        3'd2: begin cw.zlo_out = 1'b1; cw.lo_in = 1'b1; end
                        3'd3: begin cw.zhi_out = 1'b1; cw.hi_in = 1'b1; end
                        default: ;
                    endcase
                end
                // CON was loaded at the end of E3, so it is valid by E6.
                CLS_BR: begin
                    case (ex_step)
                        3'd0: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.con_in = 1'b1; end
                        3'd1: begin cw.pc_out = 1'b1; cw.y_in = 1'b1; end
                        3'd2: begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = ADDR_OP; end
                        3'd3: begin cw.zlo_out = 1'b1; cw.pc_in = CON; end
                        default: ;
                    endcase
                end
                CLS_JR:   begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_in = 1'b1; end
                CLS_IN:   begin cw.inport_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
                CLS_OUT:  begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.outport_in = 1'b1; end
                CLS_MFHI: begin cw.hi_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
                CLS_MFLO: begin cw.lo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
                default: ;
            endcase
        end
    end

    assign PCin      = cw.pc_in;
    assign IRin      = cw.ir_in;
    assign MARin     = cw.mar_in;
    assign MDRin     = cw.mdr_in;
    assign Yin       = cw.y_in;
    assign Zin       = cw.z_in;
    assign HIin      = cw.hi_in;
    assign LOin      = cw.lo_in;
    assign CONin     = cw.con_in;
    assign OUTPORTin = cw.outport_in;
    assign PCout     = cw.pc_out;
    assign MDRout    = cw.mdr_out;
    assign Yout      = cw.y_out;
    assign ZHIout    = cw.zhi_out;
    assign ZLOout    = cw.zlo_out;
    assign HIout     = cw.hi_out;
    assign LOout     = cw.lo_out;
    assign INPORTout = cw.inport_out;
    assign Cout      = cw.c_out;
    assign Gra       = cw.gra;
    assign Grb       = cw.grb;
    assign Grc       = cw.grc;
    assign Rin       = cw.r_in;
    assign Rout      = cw.r_out;
    assign BAout     = cw.ba_out;
    assign Read      = cw.read;
    assign write     = cw.write;
    assign IncPC     = cw.inc_pc;
    assign ALUop     = cw.alu_op;
    assign Run       = (state_q != ST_RST) && (state_q != ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-opcode table of expected control
// words (one per cycle) is compared against the DUT. Honours CTRL_MULDIV_EN.
module tb_control_unit;

    typedef logic [33:0] word_t;

    localparam word_t M_PCIN      = 34'd1 << 0;
    localparam word_t M_IRIN      = 34'd1 << 1;
    localparam word_t M_MARIN     = 34'd1 << 2;
    localparam word_t M_MDRIN     = 34'd1 << 3;
    localparam word_t M_YIN       = 34'd1 << 4;
    localparam word_t M_ZIN       = 34'd1 << 5;
    localparam word_t M_HIIN      = 34'd1 << 6;
    localparam word_t M_LOIN      = 34'd1 << 7;
    localparam word_t M_CONIN     = 34'd1 << 8;
    localparam word_t M_OUTPORTIN = 34'd1 << 9;
    localparam word_t M_PCOUT     = 34'd1 << 10;
    localparam word_t M_MDROUT    = 34'd1 << 11;
    localparam word_t M_ZHIOUT    = 34'd1 << 13;
    localparam word_t M_ZLOOUT    = 34'd1 << 14;
    localparam word_t M_HIOUT     = 34'd1 << 15;
    localparam word_t M_LOOUT     = 34'd1 << 16;
    localparam word_t M_INPORTOUT = 34'd1 << 17;
    localparam word_t M_COUT      = 34'd1 << 18;
    localparam word_t M_GRA       = 34'd1 << 19;
    localparam word_t M_GRB       = 34'd1 << 20;
    localparam word_t M_GRC       = 34'd1 << 21;
    localparam word_t M_RIN       = 34'd1 << 22;
    localparam word_t M_ROUT      = 34'd1 << 23;
    localparam word_t M_BAOUT     = 34'd1 << 24;
    localparam word_t M_READ      = 34'd1 << 25;
    localparam word_t M_WRITE     = 34'd1 << 26;
    localparam word_t M_INCPC     = 34'd1 << 27;
    localparam word_t M_RUN       = 34'd1 << 28;
    localparam logic [4:0] ADDR_OP = 5'b00011;

`ifdef CTRL_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    logic        Clock, Reset_n, Stop, CON;
    logic [31:0] IR;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin;
    logic PCout, MDRout, Yout, ZHIout, ZLOout, HIout, LOout, INPORTout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, Run;
    logic [4:0] ALUop;

    word_t act;
    word_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    control_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .Stop(Stop), .IR(IR), .CON(CON),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .OUTPORTin(OUTPORTin),
        .PCout(PCout), .MDRout(MDRout), .Yout(Yout), .ZHIout(ZHIout),
        .ZLOout(ZLOout), .HIout(HIout), .LOout(LOout), .INPORTout(INPORTout),
        .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Read(Read), .write(write), .IncPC(IncPC),
        .ALUop(ALUop), .Run(Run)
    );

    assign act = {ALUop, Run, IncPC, write, Read, BAout, Rout, Rin, Grc, Grb, Gra,
                  Cout, INPORTout, LOout, HIout, ZLOout, ZHIout, Yout, MDRout, PCout,
                  OUTPORTin, CONin, LOin, HIin, Zin, Yin, MDRin, MARin, IRin, PCin};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic word_t alu(input logic [4:0] op);
        return word_t'(op) << 29;
    endfunction

    function automatic void add_step(input word_t w);
        exp_q.push_back(w | M_RUN);
    endfunction

    // Expected per-cycle control words for one instruction, starting at fetch.
    function automatic void build_model(input logic [4:0] op, input logic con);
        exp_q.delete();
        add_step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        add_step(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN);
        add_step(M_MDROUT | M_IRIN);
        case (op)
            5'b00000: begin
                add_step(M_GRB | M_BAOUT | M_YIN);
                add_step(M_COUT | M_ZIN | alu(ADDR_OP));
                add_step(M_ZLOOUT | M_MARIN);
                add_step(M_READ | M_MDRIN);
                add_step(M_MDROUT | M_GRA | M_RIN);
            end
            5'b00001: begin
                add_step(M_GRB | M_BAOUT | M_YIN);
                add_step(M_COUT | M_ZIN | alu(ADDR_OP));
                add_step(M_ZLOOUT | M_GRA | M_RIN);
            end
            5'b00010: begin
                add_step(M_GRB | M_BAOUT | M_YIN);
                add_step(M_COUT | M_ZIN | alu(ADDR_OP));
                add_step(M_ZLOOUT | M_MARIN);
                add_step(M_GRA | M_ROUT | M_MDRIN);
                add_step(M_WRITE);
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                add_step(M_GRB | M_ROUT | M_YIN);
                add_step(M_GRC | M_ROUT | M_ZIN | alu(op));
                add_step(M_ZLOOUT | M_GRA | M_RIN);
            end
            5'b01100: begin
                add_step(M_GRB | M_ROUT | M_YIN);
                add_step(M_COUT | M_ZIN | alu(ADDR_OP));
                add_step(M_ZLOOUT | M_GRA | M_RIN);
            end
            5'b10010: begin
                add_step(M_GRA | M_ROUT | M_CONIN);
                add_step(M_PCOUT | M_YIN);
                add_step(M_COUT | M_ZIN | alu(ADDR_OP));
                add_step(M_ZLOOUT | (con ? M_PCIN : 34'd0));
            end
            5'b10100: add_step(M_GRA | M_ROUT | M_PCIN);
            5'b10110: add_step(M_INPORTOUT | M_GRA | M_RIN);
            5'b10111: add_step(M_GRA | M_ROUT | M_OUTPORTIN);
            5'b11000: add_step(M_HIOUT | M_GRA | M_RIN);
            5'b11001: add_step(M_LOOUT | M_GRA | M_RIN);
            5'b01111, 5'b10000: begin
                if (MULDIV_EN) begin
                    add_step(M_GRA | M_ROUT | M_YIN);
                    add_step(M_GRB | M_ROUT | M_ZIN | alu(op));
                    add_step(M_ZLOOUT | M_LOIN);
                    add_step(M_ZHIOUT | M_HIIN);
                end
            end
            default: ;
        endcase
    endfunction

    // Called at T0 (just after a rising edge); returns at the next T0 or HALT.
    task automatic run_instr(input logic [31:0] ir, input logic con, input string tag);
        build_model(ir[31:27], con);
        IR  = ir;
        CON = con;
        for (int i = 0; i < exp_q.size(); i++) begin
            #3;
            n_cmp++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL %s cycle %0d: got %09h want %09h", tag, i, act, exp_q[i]);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) begin @(posedge Clock); #1; end
        Reset_n = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Stop = 1'b0; IR = 32'h0; CON = 1'b0;
        @(posedge Clock); #1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++;
            if (act !== 34'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cycle %0d: got %09h want 0", i, act);
            end
            @(posedge Clock); #1;
        end
        Reset_n = 1'b1;
        #3;
        n_cmp++;
        if (act !== 34'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_release_rst: got %09h want 0", act);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_ld();
        run_instr(32'h0080_0055, 1'b0, "ld");
        run_instr({5'b00010, 27'h0123456}, 1'b0, "st");
        run_instr({5'b00001, 27'h0000777}, 1'b1, "ldi");
        run_instr({5'b01100, 27'h4000001}, 1'b0, "addi");
    endtask

    task automatic test_branch();
        run_instr({5'b10010, 27'h0800010}, 1'b1, "br_con1");
        run_instr({5'b10010, 27'h0800010}, 1'b0, "br_con0");
    endtask

    task automatic test_alu();
        run_instr({5'b00011, 27'h0111111}, 1'b0, "add");
        run_instr({5'b00100, 27'h0222222}, 1'b1, "sub");
        run_instr({5'b00101, 27'h0333333}, 1'b0, "and");
        run_instr({5'b00110, 27'h0444444}, 1'b1, "or");
        run_instr({5'b11111, 27'h7ffffff}, 1'b0, "undef");
        run_instr({5'b11010, 27'h0000000}, 1'b0, "nop");
    endtask

    task automatic test_single_step();
        run_instr({5'b10100, 27'h1}, 1'b0, "jr");
        run_instr({5'b10110, 27'h2}, 1'b0, "in");
        run_instr({5'b10111, 27'h3}, 1'b1, "out");
        run_instr({5'b11000, 27'h4}, 1'b0, "mfhi");
        run_instr({5'b11001, 27'h5}, 1'b1, "mflo");
    endtask

    task automatic test_muldiv();
        run_instr({5'b01111, 27'h0abcdef}, 1'b0, "mul");
        run_instr({5'b10000, 27'h0fedcba}, 1'b1, "div");
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)),
                      $sformatf("rand%0d_op%05b", n, op));
        end
    endtask

    task automatic test_stop();
        Stop = 1'b1;
        #3;
        n_cmp++;
        if (act !== M_RUN) begin
            n_fail++;
            $display("[TB] FAIL stop_t0: got %09h want %09h", act, M_RUN);
        end
        @(posedge Clock); #1;
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++;
            if (act !== 34'd0) begin
                n_fail++;
                $display("[TB] FAIL stop_halt cycle %0d: got %09h want 0", i, act);
            end
            @(posedge Clock); #1;
        end
        do_reset();
    endtask

    task automatic test_halt_opcode();
        run_instr({5'b11011, 27'h0}, 1'b0, "halt_fetch");
        for (int i = 0; i < 3; i++) begin
            #3;
            n_cmp++;
            if (act !== 34'd0) begin
                n_fail++;
                $display("[TB] FAIL halt_op cycle %0d: got %09h want 0", i, act);
            end
            @(posedge Clock); #1;
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        build_model(5'b00000, 1'b0);
        IR  = 32'h0080_0055;
        CON = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) Reset_n = 1'b0;
            #3;
            n_cmp++;
            if (act !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_pre cycle %0d: got %09h want %09h", i, act, exp_q[i]);
            end
            @(posedge Clock); #1;
        end
        for (int i = 0; i < 2; i++) begin
            #3;
            n_cmp++;
            if ((act & (M_READ | M_WRITE)) !== 34'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_mem cycle %0d: got %09h want read/write 0", i, act);
            end
            n_cmp++;
            if (act !== 34'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_rst cycle %0d: got %09h want 0", i, act);
            end
            @(posedge Clock); #1;
        end
        Reset_n = 1'b1;
        @(posedge Clock); #1;
    endtask

    initial begin
        test_reset();
        test_ld();
        test_branch();
        test_alu();
        test_single_step();
        test_muldiv();
        test_back_to_back();
        test_stop();
        test_halt_opcode();
        test_reset_mid();
        run_instr({5'b00011, 27'h0}, 1'b0, "after_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
